// File: rtl/cp0_unit_pkg.sv
// Shared CPU constants for the coprocessor-0 unit: register numbers, exception
// codes, handler address, PRId value and SR/Cause field positions.
package cp0_unit_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
   localparam logic [31:0] PRID_VALUE   = 32'h2021_0707;

   localparam int SR_IE_BIT     = 0;
   localparam int SR_EXL_BIT    = 1;
   localparam int SR_IM_LO      = 10;
   localparam int SR_IM_HI      = 15;
   localparam int CAUSE_EXC_LO  = 2;
   localparam int CAUSE_EXC_HI  = 6;
   localparam int CAUSE_IP_LO   = 10;
   localparam int CAUSE_IP_HI   = 15;
   localparam int CAUSE_BD_BIT  = 31;

endpackage

// File: rtl/cp0_unit_if.sv
// CPU <-> CP0 connection: M-stage access/exception inputs and the
// interrupt request, EPC and read-data outputs.
interface cp0_unit_if;

   logic [4:0]  A;
   logic [31:0] DIn;
   logic        We;
   logic [31:0] PC;
   logic [4:0]  ExcCode;
   logic        BD;
   logic        EXLClr;
   logic [5:0]  HWInt;
   logic        IntReq;
   logic [31:0] EPC;
   logic [31:0] DOut;

   modport master (
      output A, DIn, We, PC, ExcCode, BD, EXLClr, HWInt,
      input  IntReq, EPC, DOut
   );

   modport slave (
      input  A, DIn, We, PC, ExcCode, BD, EXLClr, HWInt,
      output IntReq, EPC, DOut
   );

endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt and exception entry,
// eret exit, and mtc0/mfc0 access.
module cp0_unit
   import cp0_unit_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   cp0_unit_if.slave  cp0_bus
);

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc_code;
   logic [31:0] r_epc;

   logic        w_int_pend;
   logic        w_exc_pend;
   logic        w_int_req;
   logic [31:0] w_exc_epc;
   logic [31:0] w_sr;
   logic [31:0] w_cause;
   logic [31:0] w_dout;

   assign w_int_pend = r_ie & ~r_exl & (|(cp0_bus.HWInt & r_im));
   assign w_exc_pend = ~r_exl & (cp0_bus.ExcCode != EXC_INT);
   // Gated by reset so a stale ExcCode cannot raise a flush while reset is held.
   assign w_int_req  = reset & (w_int_pend | w_exc_pend);

   assign w_exc_epc = cp0_bus.BD ? (cp0_bus.PC - 32'd4) : cp0_bus.PC;

   // NOTE: all register state uses non-blocking assignments so every field
   // samples the same pre-edge values of r_exl/r_ie used to form w_int_req.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_im       <= '0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip       <= '0;
         r_exc_code <= '0;
         r_epc      <= '0;
      end else begin
         r_ip <= cp0_bus.HWInt;
         if (w_int_req) begin
            r_exl      <= 1'b1;
            r_exc_code <= w_int_pend ? EXC_INT : cp0_bus.ExcCode;
            r_bd       <= cp0_bus.BD;
            r_epc      <= {w_exc_epc[31:2], 2'b00};
         end else begin
            if (cp0_bus.EXLClr) begin
               r_exl <= 1'b0;
            end
            if (cp0_bus.We && cp0_bus.A == CP0_SR) begin
               r_im  <= cp0_bus.DIn[SR_IM_HI:SR_IM_LO];
               r_exl <= cp0_bus.DIn[SR_EXL_BIT];
               r_ie  <= cp0_bus.DIn[SR_IE_BIT];
            end
            if (cp0_bus.We && cp0_bus.A == CP0_EPC) begin
               r_epc <= {cp0_bus.DIn[31:2], 2'b00};
            end
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_sr = '0;
      w_sr[SR_IM_HI:SR_IM_LO] = r_im;
      w_sr[SR_EXL_BIT]        = r_exl;
      w_sr[SR_IE_BIT]         = r_ie;

      w_cause = '0;
      w_cause[CAUSE_BD_BIT]               = r_bd;
      w_cause[CAUSE_IP_HI:CAUSE_IP_LO]    = r_ip;
      w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO]  = r_exc_code;
   end

   always_comb begin
      w_dout = '0;
      case (cp0_bus.A)
         CP0_SR:    w_dout = w_sr;
         CP0_CAUSE: w_dout = w_cause;
         CP0_EPC:   w_dout = r_epc;
         CP0_PRID:  w_dout = PRID_VALUE;
         default:   w_dout = '0;
      endcase
   end

   assign cp0_bus.IntReq = w_int_req;
   assign cp0_bus.EPC    = r_epc;
   assign cp0_bus.DOut   = w_dout;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed-vector bench for cp0_unit: register access, interrupt/exception
// entry, eret, write suppression, PC-4 wrap and mid-cycle reset.
module tb_cp0_unit;
   import cp0_unit_pkg::*;

   logic clk;
   logic reset;
   int   n_vec  = 0;
   int   n_miss = 0;

   cp0_unit_if bus ();

   cp0_unit dut (
      .clk     (clk),
      .reset   (reset),
      .cp0_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] exp);
      bus.A = addr;
      #1;
      check(tag, bus.DOut, exp);
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      bus.A   = addr;
      bus.DIn = data;
      bus.We  = 1'b1;
      tick();
      bus.We  = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      bus.A       = '0;
      bus.DIn     = '0;
      bus.We      = 1'b0;
      bus.PC      = '0;
      bus.ExcCode = EXC_INT;
      bus.BD      = 1'b0;
      bus.EXLClr  = 1'b0;
      bus.HWInt   = '0;
      $display("cp0_unit bench, handler at 0x%08h", HANDLER_ADDR);

      // Reset state, with a pending exception code that must not raise IntReq.
      #12;
      bus.ExcCode = EXC_OV;
      #1;
      check("rst_intreq", {31'b0, bus.IntReq}, 32'h0);
      check("rst_epc", bus.EPC, 32'h0);
      rd(CP0_SR, "rst_sr", 32'h0);
      rd(CP0_CAUSE, "rst_cause", 32'h0);
      bus.ExcCode = EXC_INT;
      @(negedge clk);
      reset = 1'b1;
      tick();

      rd(CP0_PRID, "prid", 32'h2021_0707);
      rd(5'd3, "unmapped", 32'h0);

      // Writes to PRId and Cause are ignored.
      mtc0(CP0_PRID, 32'h0);
      rd(CP0_PRID, "prid_ro", 32'h2021_0707);
      mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
      rd(CP0_CAUSE, "cause_ro", 32'h0);

      // SR write/readback and field masking.
      mtc0(CP0_SR, 32'h0000_FC01);
      rd(CP0_SR, "sr_fc01", 32'h0000_FC01);
      mtc0(CP0_SR, 32'hFFFF_FFFF);
      rd(CP0_SR, "sr_ones", 32'h0000_FC03);
      mtc0(CP0_SR, 32'h0000_FC01);

      // EPC write forces low bits to zero.
      mtc0(CP0_EPC, 32'h0000_3007);
      check("epc_wr", bus.EPC, 32'h0000_3004);

      // Interrupt entry.
      bus.HWInt = 6'b000100;
      bus.PC    = 32'h0000_3010;
      bus.BD    = 1'b0;
      #1;
      check("int_req", {31'b0, bus.IntReq}, 32'h1);
      tick();
      check("int_epc", bus.EPC, 32'h0000_3010);
      rd(CP0_CAUSE, "int_cause", 32'h0000_1000);
      rd(CP0_SR, "int_exl", 32'h0000_FC03);
      check("int_masked", {31'b0, bus.IntReq}, 32'h0);

      // eret with HWInt still held: EXL clears, IntReq returns next cycle.
      bus.EXLClr = 1'b1;
      bus.PC     = 32'h0000_3020;
      tick();
      bus.EXLClr = 1'b0;
      rd(CP0_SR, "eret_sr", 32'h0000_FC01);
      check("eret_reint", {31'b0, bus.IntReq}, 32'h1);
      tick();
      check("reint_epc", bus.EPC, 32'h0000_3020);
      bus.HWInt = '0;
      mtc0(CP0_SR, 32'h0000_FC01);

      // Synchronous exception in a delay slot.
      bus.ExcCode = EXC_OV;
      bus.BD      = 1'b1;
      bus.PC      = 32'h0000_3008;
      #1;
      check("exc_req", {31'b0, bus.IntReq}, 32'h1);
      tick();
      bus.ExcCode = EXC_INT;
      bus.BD      = 1'b0;
      check("exc_epc", bus.EPC, 32'h0000_3004);
      rd(CP0_CAUSE, "exc_cause", 32'h8000_0030);
      mtc0(CP0_SR, 32'h0000_FC01);

      // Interrupt beats exception; simultaneous mtc0 to EPC is dropped.
      bus.HWInt   = 6'b000001;
      bus.ExcCode = EXC_ADEL;
      bus.PC      = 32'h0000_3100;
      bus.A       = CP0_EPC;
      bus.DIn     = 32'h1234_5678;
      bus.We      = 1'b1;
      tick();
      bus.We      = 1'b0;
      bus.ExcCode = EXC_INT;
      bus.HWInt   = '0;
      check("prio_epc", bus.EPC, 32'h0000_3100);
      rd(CP0_CAUSE, "prio_cause", 32'h0000_0400);
      mtc0(CP0_SR, 32'h0000_FC01);

      // PC-4 wraps modulo 2^32; exit through eret.
      bus.ExcCode = EXC_RI;
      bus.BD      = 1'b1;
      bus.PC      = 32'h0000_0000;
      tick();
      bus.ExcCode = EXC_INT;
      bus.BD      = 1'b0;
      check("wrap_epc", bus.EPC, 32'hFFFF_FFFC);
      rd(CP0_CAUSE, "wrap_cause", 32'h8000_0028);
      bus.EXLClr = 1'b1;
      tick();
      bus.EXLClr = 1'b0;
      rd(CP0_SR, "wrap_eret", 32'h0000_FC01);

      // AdES with EXL set is masked.
      mtc0(CP0_SR, 32'h0000_FC03);
      bus.ExcCode = EXC_ADES;
      #1;
      check("exl_mask", {31'b0, bus.IntReq}, 32'h0);
      bus.ExcCode = EXC_INT;

      // IE=0 masks interrupts.
      mtc0(CP0_SR, 32'h0000_FC00);
      bus.HWInt = 6'b111111;
      #1;
      check("ie_mask", {31'b0, bus.IntReq}, 32'h0);
      bus.HWInt = '0;

      // Reset asserted between edges while IntReq is high.
      mtc0(CP0_SR, 32'h0000_FC01);
      bus.HWInt = 6'b000010;
      bus.PC    = 32'h0000_3200;
      #1;
      check("pre_rst_req", {31'b0, bus.IntReq}, 32'h1);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_req", {31'b0, bus.IntReq}, 32'h0);
      check("mid_rst_epc", bus.EPC, 32'h0);
      rd(CP0_SR, "mid_rst_sr", 32'h0);
      rd(CP0_CAUSE, "mid_rst_cause", 32'h0);
      tick();
      check("held_rst_epc", bus.EPC, 32'h0);
      rd(CP0_CAUSE, "held_rst_cause", 32'h0);
      @(negedge clk);
      reset     = 1'b1;
      bus.HWInt = '0;
      tick();
      rd(CP0_SR, "post_rst_sr", 32'h0);
      check("post_rst_epc", bus.EPC, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
